// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b - bin through one full-adder cell
// (a + ~b + ~bin), one bit per clock.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_s, r_d;
  logic [CW-1:0] r_cnt;
  logic r_c, r_bout, r_ovf;
  logic w_nb, w_sum, w_cout, w_last;
  assign w_nb = ~r_b[0];
  assign w_sum = r_a[0] ^ w_nb ^ r_c;
  assign w_cout = (r_a[0] & w_nb) | (r_c & (r_a[0] ^ w_nb));
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)  ? (start  ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (w_last ? DONE  : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
      r_d <= '0;
      r_cnt <= '0;
      r_c <= 1'b0;
      r_bout <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a <= a;
      r_b <= b;
      r_c <= ~bin;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
      r_c <= w_cout;
      r_s <= {w_sum, r_s[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
      // on the MSB bit r_c is still the carry into the MSB cell
      if (w_last) begin
        r_d <= {w_sum, r_s[WIDTH-1:1]};
        r_bout <= ~w_cout;
        r_ovf <= r_c ^ w_cout;
      end
    end
  assign busy = r_state == SHIFT;
  assign done = r_state == DONE;
  assign d = r_d;
  assign bout = r_bout;
  assign ovf = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor (WIDTH=4)
// against an integer-arithmetic reference.
module tb_serial_subtractor;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst, start, bin;
  logic [W-1:0] a, b;
  logic busy, done, bout, ovf;
  logic [W-1:0] d;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_d = '0;
  logic exp_bout = 1'b0;
  logic exp_ovf = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ovf, bout, d} from plain integer arithmetic
  function automatic logic [W+1:0] ref_sub(input int xa, input int xb, input int xbin);
    int diff, sa, sb, sd;
    logic [W-1:0] rd;
    diff = xa - xb - xbin;
    sa = (xa >= 2 ** (W - 1)) ? xa - 2 ** W : xa;
    sb = (xb >= 2 ** (W - 1)) ? xb - 2 ** W : xb;
    sd = sa - sb - xbin;
    rd = W'(diff);
    return {(sd < -(2 ** (W - 1))) || (sd > 2 ** (W - 1) - 1), xa < xb + xbin, rd};
  endfunction

  task automatic check_hold(input string tag);
    chk({tag, "_d_hold"}, 32'(d), 32'(exp_d));
    chk({tag, "_bout_hold"}, 32'(bout), 32'(exp_bout));
    chk({tag, "_ovf_hold"}, 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                       input bit glitch, input string tag);
    logic [W+1:0] r;
    r = ref_sub(int'(xa), int'(xb), int'(xbin));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    a = xa; b = xb; bin = xbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_nodone"}, 32'(done), 0);
      check_hold(tag);
      if (glitch && k == 1) begin
        start = 1'b1; a = 1; b = 1; bin = 1'b0;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    exp_d = r[W-1:0]; exp_bout = r[W]; exp_ovf = r[W+1];
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_d"}, 32'(d), 32'(exp_d));
    chk({tag, "_bout"}, 32'(bout), 32'(exp_bout));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_idle_after"}, 32'(busy), 0);
    check_hold({tag, "_idle"});
  endtask

  initial begin
    int pulses, first, last;
    bit overlap;
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_bout", 32'(bout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(4'd9, 4'd3, 1'b0, 0, "v9m3");
    chk("v9m3_d6", 32'(d), 6);
    do_op(4'd3, 4'd9, 1'b0, 0, "v3m9");
    chk("v3m9_ovf", 32'(ovf), 1);
    do_op(4'd0, 4'd0, 1'b1, 0, "v0m0b");
    chk("v0m0b_dF", 32'(d), 15);
    do_op(4'd8, 4'd1, 1'b0, 0, "v8m1");
    chk("v8m1_ovf", 32'(ovf), 1);
    do_op(4'd9, 4'd3, 1'b0, 1, "ignore");
    chk("ignore_d6", 32'(d), 6);
    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), i[0], "rand");
    // abort during the second SHIFT cycle; start under reset must be ignored
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_d", 32'(d), 0);
    chk("abort_bout", 32'(bout), 0);
    chk("abort_ovf", 32'(ovf), 0);
    exp_d = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("abort_nodone", 32'(done), 0);
      chk("abort_nobusy", 32'(busy), 0);
      @(negedge clk);
    end
    do_op(4'd5, 4'd2, 1'b0, 0, "post_rst");
    chk("post_rst_d3", 32'(d), 3);
    // start held for 12 edges: two operations, done pulses 6 cycles apart
    ra = W'($urandom); rb = W'($urandom);
    r = ref_sub(int'(ra), int'(rb), 0);
    @(negedge clk);
    a = ra; b = rb; bin = 1'b0; start = 1'b1;
    pulses = 0; first = -1; last = -1; overlap = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 11) start = 1'b0;
      if (busy && done) overlap = 1;
      if (done) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("b2b_pulses", 32'(pulses), 2);
    chk("b2b_first", 32'(first), 4);
    chk("b2b_gap", 32'(last - first), 6);
    chk("b2b_overlap", 32'(overlap), 0);
    chk("b2b_d", 32'(d), 32'(r[W-1:0]));
    chk("b2b_bout", 32'(bout), 32'(r[W]));
    chk("b2b_ovf", 32'(ovf), 32'(r[W+1]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
